// File: rtl/fpmul_arb_pkg.sv
// Shared defaults and types for the two-requester floating-point multiplier arbiter.
package fpmul_arb_pkg;

  localparam int unsigned W_DEF     = 32;
  localparam int unsigned LAT_DEF   = 4;
  localparam int unsigned DEPTH_DEF = 2;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/fpmul_rsp_fifo.sv
// Per-requester response buffer: DEPTH-entry synchronous FIFO, head visible combinationally.
module fpmul_rsp_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_wr && !do_rd) count_d = count_q + CW'(1);
    else if (!do_wr && do_rd) count_d = count_q - CW'(1);
  end

  // Storage is cleared on reset so the head reads zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin, credit-based sharing of one fixed-latency multiplier between two requesters,
// with a tag pipeline routing each product into its requester's response FIFO.
module fpmul_arbiter
  import fpmul_arb_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned LAT   = LAT_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         mul_valid,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic [W-1:0] mul_result,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [1:0]    elig, grant, rsp_hs, fifo_wr, fifo_full, fifo_empty;
  logic [CW-1:0] credit_q [2];
  logic [CW-1:0] credit_d [2];
  logic          last_q, last_d;
  tag_t          tag_q [LAT];
  tag_t          tag_last;

  // Grant: lone eligible requester wins; on a tie the one not granted last wins.
  always_comb begin
    elig   = '0;
    grant  = '0;
    last_d = last_q;
    mul_a  = '0;
    mul_b  = '0;
    elig[0] = rst_n & req0_valid & (credit_q[0] != '0);
    elig[1] = rst_n & req1_valid & (credit_q[1] != '0);
    if (elig[0] && (!elig[1] || last_q)) grant[0] = 1'b1;
    else if (elig[1])                    grant[1] = 1'b1;
    if (grant[0]) begin
      mul_a  = req0_a;
      mul_b  = req0_b;
      last_d = 1'b0;
    end else if (grant[1]) begin
      mul_a  = req1_a;
      mul_b  = req1_b;
      last_d = 1'b1;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign mul_valid  = |grant;

  assign rsp0_valid = ~fifo_empty[0];
  assign rsp1_valid = ~fifo_empty[1];
  assign rsp_hs     = {rsp1_valid & rsp1_ready, rsp0_valid & rsp0_ready};

  // A credit stands for one FIFO slot, reserved at grant and returned at handshake.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      credit_d[n] = credit_q[n];
      if (grant[n] && !rsp_hs[n])      credit_d[n] = credit_q[n] - CW'(1);
      else if (!grant[n] && rsp_hs[n]) credit_d[n] = credit_q[n] + CW'(1);
    end
  end

  assign tag_last   = tag_q[LAT-1];
  assign fifo_wr[0] = tag_last.valid && (tag_last.id == req_id_t'(1'b0));
  assign fifo_wr[1] = tag_last.valid && (tag_last.id == req_id_t'(1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q[0] <= CW'(DEPTH);
      credit_q[1] <= CW'(DEPTH);
      last_q      <= 1'b1;
      for (int i = 0; i < int'(LAT); i++) tag_q[i] <= '0;
    end else begin
      credit_q[0] <= credit_d[0];
      credit_q[1] <= credit_d[1];
      last_q      <= last_d;
      tag_q[0]    <= '{valid: mul_valid, id: req_id_t'(grant[1])};
      for (int i = 1; i < int'(LAT); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  fpmul_rsp_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (fifo_wr[0]),
    .wr_data_i (mul_result),
    .rd_en_i   (rsp_hs[0]),
    .rd_data_o (rsp0_data),
    .full_o    (fifo_full[0]),
    .empty_o   (fifo_empty[0])
  );

  fpmul_rsp_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (fifo_wr[1]),
    .wr_data_i (mul_result),
    .rd_en_i   (rsp_hs[1]),
    .rd_data_o (rsp1_data),
    .full_o    (fifo_full[1]),
    .empty_o   (fifo_empty[1])
  );

  a_no_ovf0 : assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wr[0] && fifo_full[0]));
  a_no_ovf1 : assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wr[1] && fifo_full[1]));
  a_credit0 : assert property (@(posedge clk) disable iff (!rst_n) credit_q[0] <= CW'(DEPTH));
  a_credit1 : assert property (@(posedge clk) disable iff (!rst_n) credit_q[1] <= CW'(DEPTH));

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Randomized and directed bench for fpmul_arbiter against a transaction-level model
// of credits, round-robin choice, multiplier latency and per-requester response queues.
module tb_fpmul_arbiter;

  localparam int W     = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 2;

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         mul_valid;
  logic [W-1:0] mul_a, mul_b, mul_result;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp0_data, rsp1_data;

  fpmul_arbiter #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .mul_valid  (mul_valid),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-precision multiply through double arithmetic; operands are chosen so products are exact.
  function automatic real sp2real(input logic [31:0] x);
    if (x[30:0] == 31'd0) return 0.0;
    return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] sp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    d = $realtobits(sp2real(a) * sp2real(b));
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] rnd_op();
    return {1'($urandom), 8'($urandom_range(154, 100)), 11'($urandom), 12'd0};
  endfunction

  // LAT-stage multiplier: product of the pair issued in cycle T is presented during T+LAT.
  logic [W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_valid ? sp_mul(mul_a, mul_b) : '0;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[LAT-1];

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } flight_t;

  int          n_chk, n_fail, cyc;
  int          m_credit [2];
  int          m_last;
  flight_t     infl [$];
  logic [31:0] fq0 [$];
  logic [31:0] fq1 [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare against the model, then advance the model.
  task automatic step(input bit rst, input bit v0, input bit v1,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1,
                      input bit r0, input bit r1);
    int      gid;
    bit      e0, e1;
    flight_t f;
    @(negedge clk);
    rst_n = ~rst;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp0_ready = r0; rsp1_ready = r1;
    #1;
    if (rst) begin
      m_credit[0] = DEPTH; m_credit[1] = DEPTH; m_last = 1;
      infl.delete(); fq0.delete(); fq1.delete();
    end
    e0 = !rst && v0 && (m_credit[0] > 0);
    e1 = !rst && v1 && (m_credit[1] > 0);
    gid = -1;
    if (e0 && e1) gid = 1 - m_last;
    else if (e0)  gid = 0;
    else if (e1)  gid = 1;
    check_eq("req0_ready", 32'(req0_ready), 32'(gid == 0));
    check_eq("req1_ready", 32'(req1_ready), 32'(gid == 1));
    check_eq("mul_valid", 32'(mul_valid), 32'(gid >= 0));
    check_eq("mul_a", mul_a, (gid == 0) ? a0 : (gid == 1) ? a1 : 32'd0);
    check_eq("mul_b", mul_b, (gid == 0) ? b0 : (gid == 1) ? b1 : 32'd0);
    check_eq("rsp0_valid", 32'(rsp0_valid), 32'(fq0.size() > 0));
    check_eq("rsp1_valid", 32'(rsp1_valid), 32'(fq1.size() > 0));
    if (fq0.size() > 0) check_eq("rsp0_data", rsp0_data, fq0[0]);
    else if (rst)       check_eq("rsp0_data_rst", rsp0_data, 32'd0);
    if (fq1.size() > 0) check_eq("rsp1_data", rsp1_data, fq1[0]);
    else if (rst)       check_eq("rsp1_data_rst", rsp1_data, 32'd0);
    if (fq0.size() > 0 && r0) begin void'(fq0.pop_front()); m_credit[0]++; end
    if (fq1.size() > 0 && r1) begin void'(fq1.pop_front()); m_credit[1]++; end
    if (gid >= 0) begin
      m_credit[gid]--;
      m_last = gid;
      f.id   = gid;
      f.data = (gid == 0) ? sp_mul(a0, b0) : sp_mul(a1, b1);
      f.due  = cyc + LAT;
      infl.push_back(f);
    end
    while (infl.size() > 0 && infl[0].due == cyc) begin
      f = infl.pop_front();
      if (f.id == 0) fq0.push_back(f.data);
      else           fq1.push_back(f.data);
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit r0, input bit r1);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, r0, r1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g1cnt;
    n_chk = 0; n_fail = 0; cyc = 0;
    m_credit[0] = DEPTH; m_credit[1] = DEPTH; m_last = 1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    repeat (3) do_reset();
    idle(5, 1'b1, 1'b1);

    // Single issue 2.0 x 3.0 from requester 0
    step(1'b0, 1'b1, 1'b0, 32'h4000_0000, 32'h4040_0000, 32'd0, 32'd0, 1'b1, 1'b1);
    check_eq("single_grant", 32'(req0_ready), 32'd1);
    for (int k = 1; k <= LAT + 1; k++) begin
      idle(1, 1'b1, 1'b1);
      if (k == LAT) check_eq("single_early", 32'(rsp0_valid), 32'd0);
      if (k == LAT + 1) begin
        check_eq("single_valid", 32'(rsp0_valid), 32'd1);
        check_eq("single_data", rsp0_data, 32'h40C0_0000);
      end
      check_eq("single_rsp1", 32'(rsp1_valid), 32'd0);
    end

    // Tie from reset: grants alternate starting with requester 0
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), 1'b1, 1'b1);
      if (k < 4) begin
        check_eq("tie_g0", 32'(req0_ready), 32'(k % 2 == 0));
        check_eq("tie_g1", 32'(req1_ready), 32'(k % 2 == 1));
      end
    end
    idle(LAT + 4, 1'b1, 1'b1);

    // Back-pressure on responder 1
    do_reset();
    g1cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b1, 1'b1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), 1'b1, 1'b0);
      g1cnt += int'(req1_ready);
    end
    check_eq("bp_g1_count", 32'(g1cnt), 32'd2);
    check_eq("bp_ready1_low", 32'(req1_ready), 32'd0);
    check_eq("bp_rsp1_held", 32'(rsp1_valid), 32'd1);

    // Release: held products drain in order, requester 1 resumes
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, rnd_op(), rnd_op(), 1'b1, 1'b1);
      if (k == 0) check_eq("rel_first_hs", 32'(rsp1_valid), 32'd1);
    end
    idle(LAT + 4, 1'b1, 1'b1);

    // Reset while three products are in flight
    do_reset();
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b1, 1'b1, rnd_op(), rnd_op(), rnd_op(), rnd_op(), 1'b1, 1'b1);
    idle(1, 1'b1, 1'b1);
    do_reset();
    for (int k = 0; k < LAT + 3; k++) begin
      idle(1, 1'b1, 1'b1);
      check_eq("flush_rsp0", 32'(rsp0_valid), 32'd0);
      check_eq("flush_rsp1", 32'(rsp1_valid), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, rnd_op(), rnd_op(), 32'd0, 32'd0, 1'b1, 1'b1);
    check_eq("fresh_grant", 32'(req0_ready), 32'd1);
    for (int k = 1; k <= LAT + 1; k++) begin
      idle(1, 1'b1, 1'b1);
      if (k == LAT + 1) check_eq("fresh_valid", 32'(rsp0_valid), 32'd1);
    end

    // Random traffic with random back-pressure
    repeat (400)
      step(1'b0, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
           rnd_op(), rnd_op(), rnd_op(), rnd_op(),
           $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
    idle(LAT + 8, 1'b1, 1'b1);
    check_eq("drained0", 32'(rsp0_valid), 32'd0);
    check_eq("drained1", 32'(rsp1_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
